// File: rtl/rc5_core_param.sv
// Parametrised RC5 block cipher engine: encrypt and decrypt, one half-round per clock.
// The expanded key table comes from an upstream key-schedule block and is captured on accept.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request handshake; in_mode 0 = encrypt, 1 = decrypt
//   in_data              block {A,B}, A in the upper W bits
//   key_s                key table, S[i] = key_s[i*W +: W]
//   out_valid/out_ready  result handshake; out_data {A,B}, out_mode mode of the result
//   busy                 high whenever the engine is not idle
module rc5_core_param #(
  parameter int unsigned W = 16,
  parameter int unsigned R = 12,
  localparam int unsigned NK = 2 * R + 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [2*W-1:0]  in_data,
  input  logic [NK*W-1:0] key_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_data,
  output logic            out_mode,
  output logic            busy
);

  localparam int unsigned LW = $clog2(W);
  localparam logic [7:0] RLast = 8'(R);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StHalfA = 3'd2,
    StHalfB = 3'd3,
    StPost  = 3'd4,
    StOut   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [7:0]      i_q, i_d;
  logic            mode_q, mode_d;
  logic [NK*W-1:0] key_q, key_d;
  logic [2*W-1:0]  out_data_q, out_data_d;
  logic            out_mode_q, out_mode_d;

  // Rotates use only the low log2(W) bits of the amount; the doubled word makes wrap-around free.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [W-1:0] amt);
    logic [2*W-1:0] t;
    t = {x, x} << amt[LW-1:0];
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [W-1:0] amt);
    logic [2*W-1:0] t;
    t = {x, x} >> amt[LW-1:0];
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] s_word(input logic [NK*W-1:0] key, input int unsigned idx);
    return key[idx*W +: W];
  endfunction

  logic [31:0] idx_a, idx_b;
  assign idx_a = 2 * 32'(i_q);
  assign idx_b = idx_a + 32'd1;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    i_d        = i_q;
    mode_d     = mode_q;
    key_d      = key_q;
    out_data_d = out_data_q;
    out_mode_d = out_mode_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d    = in_data[2*W-1:W];
          b_d    = in_data[W-1:0];
          mode_d = in_mode;
          key_d  = key_s;
          if (in_mode) begin
            i_d     = RLast;
            state_d = StHalfB;
          end else begin
            state_d = StPre;
          end
        end
      end
      StPre: begin
        a_d     = a_q + s_word(key_q, 0);
        b_d     = b_q + s_word(key_q, 1);
        i_d     = 8'd1;
        state_d = StHalfA;
      end
      StHalfA: begin
        if (!mode_q) begin
          a_d     = rotl(a_q ^ b_q, b_q) + s_word(key_q, idx_a);
          state_d = StHalfB;
        end else begin
          a_d = rotr(a_q - s_word(key_q, idx_a), b_q) ^ b_q;
          if (i_q == 8'd1) begin
            state_d = StPost;
          end else begin
            i_d     = i_q - 8'd1;
            state_d = StHalfB;
          end
        end
      end
      StHalfB: begin
        if (!mode_q) begin
          b_d = rotl(b_q ^ a_q, a_q) + s_word(key_q, idx_b);
          if (i_q == RLast) begin
            out_data_d = {a_q, b_d};
            out_mode_d = 1'b0;
            state_d    = StOut;
          end else begin
            i_d     = i_q + 8'd1;
            state_d = StHalfA;
          end
        end else begin
          b_d     = rotr(b_q - s_word(key_q, idx_b), a_q) ^ a_q;
          state_d = StHalfA;
        end
      end
      StPost: begin
        b_d        = b_q - s_word(key_q, 1);
        a_d        = a_q - s_word(key_q, 0);
        out_data_d = {a_d, b_d};
        out_mode_d = 1'b1;
        state_d    = StOut;
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      i_q        <= '0;
      mode_q     <= 1'b0;
      key_q      <= '0;
      out_data_q <= '0;
      out_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      i_q        <= i_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_rc5_core_param.sv
// Scoreboard bench for rc5_core_param: a small instance (W=8, R=1) for directed vectors and
// handshake corner cases, and a default instance (W=16, R=12) for random round-trips.
module tb_rc5_core_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] data;
    logic        mode;
    int          acc;
  } exp_t;

  exp_t s_q[$];
  exp_t b_q[$];

  // Small instance
  logic        s_reset, s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready;
  logic        s_out_mode, s_busy;
  logic [15:0] s_in_data, s_out_data;
  logic [31:0] s_key;

  // Default instance
  logic         b_reset, b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic         b_out_mode, b_busy;
  logic [31:0]  b_in_data, b_out_data;
  logic [415:0] b_key;

  rc5_core_param #(.W(8), .R(1)) u_small (
    .clock     (clock),
    .reset     (s_reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_mode   (s_in_mode),
    .in_data   (s_in_data),
    .key_s     (s_key),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_mode  (s_out_mode),
    .busy      (s_busy)
  );

  rc5_core_param #(.W(16), .R(12)) u_big (
    .clock     (clock),
    .reset     (b_reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_mode   (b_in_mode),
    .in_data   (b_in_data),
    .key_s     (b_key),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_mode  (b_out_mode),
    .busy      (b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] rol16(input logic [15:0] x, input logic [3:0] s);
    if (s == 4'd0) return x;
    return (x << s) | (x >> (16 - int'(s)));
  endfunction

  // Straight RC5-16/12 encryption used as the reference for the default instance.
  function automatic logic [31:0] ref_enc(input logic [31:0] blk, input logic [415:0] k);
    logic [15:0] a, b;
    a = blk[31:16] + k[15:0];
    b = blk[15:0] + k[31:16];
    for (int i = 1; i <= 12; i++) begin
      a = rol16(a ^ b, b[3:0]) + k[(2*i)*16 +: 16];
      b = rol16(b ^ a, a[3:0]) + k[(2*i+1)*16 +: 16];
    end
    return {a, b};
  endfunction

  // Monitors: compare at the negedge preceding each output handshake; latency measured to the
  // first cycle out_valid is seen high.
  initial begin : s_mon
    logic prev;
    int   rise;
    exp_t e;
    prev = 1'b0;
    rise = 0;
    forever begin
      @(negedge clock);
      if (s_out_valid && !prev) rise = cyc;
      prev = s_out_valid;
      if (s_out_valid && s_out_ready) begin
        if (s_q.size() == 0) begin
          check("s_unexpected_out", s_out_valid, 0);
        end else begin
          e = s_q.pop_front();
          check("s_data", s_out_data, e.data[15:0]);
          check("s_mode", s_out_mode, e.mode);
          check("s_latency", rise - e.acc, 3);
        end
      end
    end
  end

  initial begin : b_mon
    logic prev;
    int   rise;
    exp_t e;
    prev = 1'b0;
    rise = 0;
    forever begin
      @(negedge clock);
      if (b_out_valid && !prev) rise = cyc;
      prev = b_out_valid;
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected_out", b_out_valid, 0);
        end else begin
          e = b_q.pop_front();
          check("b_data", b_out_data, e.data);
          check("b_mode", b_out_mode, e.mode);
          check("b_latency", rise - e.acc, 25);
        end
      end
    end
  end

  // Issue tasks are entered just after a posedge and return just after the accept edge.
  task automatic s_issue(input logic mode, input logic [15:0] data, input logic [15:0] exp,
                         input bit push, input bit zero_key);
    int n;
    s_in_valid = 1'b1;
    s_in_mode  = mode;
    s_in_data  = data;
    n = 0;
    @(negedge clock);
    while (!s_in_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (!s_in_ready) check("s_accept_timeout", s_in_ready, 1);
    else if (push) s_q.push_back('{data: {16'd0, exp}, mode: mode, acc: cyc + 1});
    @(posedge clock);
    #1;
    s_in_valid = 1'b0;
    if (zero_key) s_key = '0;
  endtask

  task automatic s_wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (!s_in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!s_in_ready) check("s_idle_timeout", s_in_ready, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic b_issue(input logic mode, input logic [31:0] data, input logic [31:0] exp);
    int n;
    b_in_valid = 1'b1;
    b_in_mode  = mode;
    b_in_data  = data;
    n = 0;
    @(negedge clock);
    while (!b_in_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (!b_in_ready) check("b_accept_timeout", b_in_ready, 1);
    else b_q.push_back('{data: exp, mode: mode, acc: cyc + 1});
    @(posedge clock);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic b_wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (!b_in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!b_in_ready) check("b_idle_timeout", b_in_ready, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] pt, ct;
    int n;
    s_reset = 1'b1;  s_in_valid = 1'b0;  s_in_mode = 1'b0;  s_in_data = '0;  s_out_ready = 1'b1;
    b_reset = 1'b1;  b_in_valid = 1'b0;  b_in_mode = 1'b0;  b_in_data = '0;  b_out_ready = 1'b1;
    s_key = {8'hFF, 8'hFF, 8'h10, 8'h20};
    b_key = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", s_in_ready, 1);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_out_data", s_out_data, 16'h0000);
    check("rst_out_mode", s_out_mode, 0);
    check("rst_busy", s_busy, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    @(posedge clock);
    #1;
    s_reset = 1'b0;
    b_reset = 1'b0;

    // Directed encrypt / decrypt vectors
    s_issue(1'b0, 16'h0000, 16'h2F9E, 1, 0);  s_wait_idle();
    s_issue(1'b0, 16'h0102, 16'hCBCD, 1, 0);  s_wait_idle();
    s_issue(1'b1, 16'h2F9E, 16'h0000, 1, 0);  s_wait_idle();
    s_issue(1'b1, 16'hCBCD, 16'h0102, 1, 0);  s_wait_idle();

    // Back-pressure with ignored in_valid pulses
    s_out_ready = 1'b0;
    s_issue(1'b0, 16'h0000, 16'h2F9E, 1, 0);
    n = 0;
    @(negedge clock);
    while (!s_out_valid && n < 50) begin
      n++;
      @(negedge clock);
    end
    check("s_bp_valid_rise", s_out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      s_in_valid = (k % 2 == 0);
      s_in_mode  = 1'b1;
      s_in_data  = 16'h1234;
      @(negedge clock);
      check("s_bp_valid", s_out_valid, 1);
      check("s_bp_data", s_out_data, 16'h2F9E);
      check("s_bp_in_ready", s_in_ready, 0);
      check("s_bp_busy", s_busy, 1);
    end
    @(posedge clock);
    #1;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("s_bp_release_ready", s_in_ready, 1);
    repeat (3) @(negedge clock);
    check("s_bp_no_ghost_valid", s_out_valid, 0);
    check("s_bp_no_ghost_busy", s_busy, 0);
    check("s_out_hold_after", s_out_data, 16'h2F9E);
    @(posedge clock);
    #1;

    // Reset one cycle after accept discards the block
    s_issue(1'b0, 16'h0000, 16'h0000, 0, 0);
    s_reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("s_midrst_in_ready", s_in_ready, 1);
    check("s_midrst_out_valid", s_out_valid, 0);
    check("s_midrst_busy", s_busy, 0);
    check("s_midrst_out_data", s_out_data, 16'h0000);
    s_reset = 1'b0;
    @(posedge clock);
    #1;
    s_issue(1'b0, 16'h0000, 16'h2F9E, 1, 0);  s_wait_idle();

    // Key table changes after accept do not affect the in-flight block
    s_issue(1'b0, 16'h0000, 16'h2F9E, 1, 1);  s_wait_idle();
    // With the all-zero key now live, a zero block encrypts to zero
    s_issue(1'b0, 16'h0000, 16'h0000, 1, 0);  s_wait_idle();
    s_key = {8'hFF, 8'hFF, 8'h10, 8'h20};

    // Default-size random round-trips
    for (int t = 0; t < 300; t++) begin
      pt = $urandom;
      for (int j = 0; j < 13; j++) b_key[j*32 +: 32] = $urandom;
      ct = ref_enc(pt, b_key);
      b_issue(1'b0, pt, ct);  b_wait_idle();
      b_issue(1'b1, ct, pt);  b_wait_idle();
    end

    repeat (3) @(negedge clock);
    check("s_drain", s_q.size(), 0);
    check("b_drain", b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
